// File: rtl/lpf_sched_pkg.sv
// Shared types and helpers for the time-shared low-pass filter scheduler.
package lpf_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam int CW_DEF = 2;

  // Default-width cutoff-select code; the engine's coefficient table index.
  typedef logic [CW_DEF-1:0] cut_code_t;

  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lpf_tdm_sched_if.sv
// Handshake between the scheduler and the shared first-order update engine.
interface lpf_tdm_sched_if
  import lpf_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 2
);
  localparam int CHW = chw(NCH);

  logic           ENG_START;
  logic [CHW-1:0] ENG_CH;
  logic [CW-1:0]  ENG_SEL;
  logic           ENG_DONE;

  modport master (output ENG_START, ENG_CH, ENG_SEL, input ENG_DONE);
  modport slave  (input ENG_START, ENG_CH, ENG_SEL, output ENG_DONE);

endinterface

// File: rtl/lpf_rr_pick.sv
// Combinational round-robin finder: first set bit of pending at or after ptr,
// wrapping modulo NCH.
module lpf_rr_pick
  import lpf_sched_pkg::*;
#(
  parameter int NCH = 4,
  localparam int CHW = chw(NCH)
) (
  input  logic [NCH-1:0] pending,
  input  logic [CHW-1:0] ptr,
  output logic           valid,
  output logic [CHW-1:0] idx
);

  logic [CHW-1:0] cand;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // Walk from the farthest offset back to the pointer so the nearest hit wins.
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = CHW'((int'(ptr) + k) % NCH);
      if (pending[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/lpf_tdm_sched.sv
// Round-robin scheduler sharing one low-pass update engine among NCH channels,
// with a built-in sample-period tick and a per-channel cutoff table.
module lpf_tdm_sched
  import lpf_sched_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int CW       = 2,
  parameter int TICK_DIV = 16,
  parameter int TMO      = 15
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic [NCH-1:0]      REQ,
  input  logic                CFG_WE,
  input  logic [chw(NCH)-1:0] CFG_CH,
  input  logic [CW-1:0]       CFG_SEL,
  lpf_tdm_sched_if.master     eng,
  output logic [NCH-1:0]      ACK,
  output logic                TICK,
  output logic                BUSY,
  output logic [NCH-1:0]      OVR,
  output logic                ERR,
  input  logic                ERR_CLR
);

  localparam int CHW  = chw(NCH);
  localparam int CNTW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMOW = $clog2(TMO + 1);

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;
  logic [NCH-1:0]  pend_q, pend_d;
  logic [CHW-1:0]  ptr_q, ptr_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [CW-1:0]   sel_q, sel_d;
  logic            start_q, start_d;
  logic [NCH-1:0]  ack_q, ack_d;
  logic            busy_q, busy_d;
  logic [NCH-1:0]  ovr_q, ovr_d;
  logic            err_q, err_d;
  logic [TMOW-1:0] tmo_q, tmo_d;
  logic [CW-1:0]   tbl_q [NCH];
  logic [CW-1:0]   tbl_d [NCH];

  logic            pick_valid;
  logic [CHW-1:0]  pick_idx;
  logic [NCH-1:0]  clr;
  logic [NCH-1:0]  pend_kept;
  logic [NCH-1:0]  ovr_set;
  logic            err_set;
  logic [CHW-1:0]  ptr_after;

  lpf_rr_pick #(.NCH(NCH)) u_pick (
    .pending (pend_q),
    .ptr     (ptr_q),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  assign ptr_after = (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + CHW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    ptr_d     = ptr_q;
    ch_d      = ch_q;
    sel_d     = sel_q;
    start_d   = 1'b0;
    ack_d     = '0;
    tmo_d     = tmo_q;
    clr       = '0;
    err_set   = 1'b0;
    for (int i = 0; i < NCH; i++) tbl_d[i] = tbl_q[i];

    if (EN) begin
      if (cnt_q == CNTW'(TICK_DIV - 1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end

    // The table is written unconditionally; ENG_SEL holds its own latched copy.
    if (CFG_WE) tbl_d[CFG_CH] = CFG_SEL;

    case (state_q)
      IDLE: begin
        if (EN && pick_valid) begin
          ch_d    = pick_idx;
          sel_d   = tbl_q[pick_idx];
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = TMOW'(TMO);
        state_d = WAIT;
      end
      WAIT: begin
        if (eng.ENG_DONE) begin
          ack_d[ch_q] = 1'b1;
          clr[ch_q]   = 1'b1;
          ptr_d       = ptr_after;
          state_d     = IDLE;
        end else if (tmo_q == TMOW'(1)) begin
          // Last allowed cycle without DONE: drop the sample, no ACK.
          err_set   = 1'b1;
          clr[ch_q] = 1'b1;
          ptr_d     = ptr_after;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q - TMOW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A completion clear lands before the tick capture, so a re-request on
    // the channel just finished is not an overrun.
    pend_kept = pend_q & ~clr;
    ovr_set   = tick_q ? (pend_kept & REQ) : '0;
    pend_d    = tick_q ? (pend_kept | REQ) : pend_kept;
    ovr_d     = (ERR_CLR ? '0 : ovr_q) | ovr_set;
    err_d     = (ERR_CLR ? 1'b0 : err_q) | err_set;
    busy_d    = (state_d != IDLE);
  end

  // NOTE: clocked state uses non-blocking assignments only; blocking stays in always_comb.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      pend_q  <= '0;
      ptr_q   <= '0;
      ch_q    <= '0;
      sel_q   <= '0;
      start_q <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      // NOTE: the cutoff table is a handful of flops that must read 0 after reset, so it is reset too.
      tbl_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      tbl_q   <= tbl_d;
    end
  end

  assign eng.ENG_START = start_q;
  assign eng.ENG_CH    = ch_q;
  assign eng.ENG_SEL   = sel_q;
  assign ACK           = ack_q;
  assign TICK          = tick_q;
  assign BUSY          = busy_q;
  assign OVR           = ovr_q;
  assign ERR           = err_q;

endmodule

// File: tb/tb_lpf_tdm_sched.sv
// Directed bench for lpf_tdm_sched: tick period, round-robin service, timeout,
// overrun, config during WAIT, async reset and enable hold.
module tb_lpf_tdm_sched;
  import lpf_sched_pkg::*;

  localparam int NCH      = 4;
  localparam int CW       = 2;
  localparam int TICK_DIV = 16;
  localparam int TMO      = 15;
  localparam int CHW      = 2;

  logic           clk     = 1'b0;
  logic           rst_n   = 1'b0;
  logic           en      = 1'b0;
  logic [NCH-1:0] req     = '0;
  logic           cfg_we  = 1'b0;
  logic [CHW-1:0] cfg_ch  = '0;
  cut_code_t      cfg_sel = '0;
  logic           err_clr = 1'b0;
  logic [NCH-1:0] ack, ovr;
  logic           tick, busy, err;

  int n_tests   = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  int ack_cnt   = 0;

  lpf_tdm_sched_if #(.NCH(NCH), .CW(CW)) eng_if ();

  lpf_tdm_sched #(.NCH(NCH), .CW(CW), .TICK_DIV(TICK_DIV), .TMO(TMO)) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .EN      (en),
    .REQ     (req),
    .CFG_WE  (cfg_we),
    .CFG_CH  (cfg_ch),
    .CFG_SEL (cfg_sel),
    .eng     (eng_if),
    .ACK     (ack),
    .TICK    (tick),
    .BUSY    (busy),
    .OVR     (ovr),
    .ERR     (err),
    .ERR_CLR (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (eng_if.ENG_START === 1'b1) start_cnt++;
    if (ack !== '0) ack_cnt++;
  endtask

  task automatic wait_tick(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no TICK within 40 cycles", name);
    end
  endtask

  task automatic wait_start(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (eng_if.ENG_START === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no ENG_START within 10 cycles", name);
    end
  endtask

  task automatic test_reset();
    int ticks;
    #2;
    n_tests++;
    if ({ack, tick, busy, ovr, err, eng_if.ENG_START, eng_if.ENG_CH, eng_if.ENG_SEL} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b tick=%b busy=%b ovr=%b err=%b start=%b ch=%0d sel=%0d want all 0",
               ack, tick, busy, ovr, err, eng_if.ENG_START, eng_if.ENG_CH, eng_if.ENG_SEL);
    end
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    ticks = 0;
    for (int i = 1; i <= 15; i++) begin step(); if (tick === 1'b1) ticks++; end
    n_tests++;
    if (ticks !== 0) begin n_fail++; $display("FAIL tick_early: got %0d ticks in 15 cycles want 0", ticks); end
    step();
    n_tests++;
    if (tick !== 1'b1) begin n_fail++; $display("FAIL tick_first: got %b at cycle 16 want 1", tick); end
    ticks = 0;
    for (int i = 1; i <= 15; i++) begin step(); if (tick === 1'b1) ticks++; end
    step();
    n_tests++;
    if (ticks !== 0 || tick !== 1'b1) begin
      n_fail++; $display("FAIL tick_period: got %0d mid ticks, tick=%b at 32 want 0 and 1", ticks, tick);
    end
    n_tests++;
    if (start_cnt !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_start: got starts=%0d busy=%b want 0 0", start_cnt, busy);
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < NCH; i++) begin
      cfg_we = 1'b1; cfg_ch = CHW'(i); cfg_sel = cut_code_t'(i);
      step();
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_ch[3] = '{0, 1, 3};
    int n0;
    req = 4'b1011;
    wait_tick("rr_tick");
    step(); req = '0;
    step();
    n_tests++;
    if (eng_if.ENG_START !== 1'b1) begin
      n_fail++; $display("FAIL rr_latency: got start=%b 2 cycles after TICK want 1", eng_if.ENG_START);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) wait_start("rr_next_start");
      n_tests++;
      if (eng_if.ENG_CH !== CHW'(exp_ch[k]) || eng_if.ENG_SEL !== CW'(exp_ch[k])) begin
        n_fail++; $display("FAIL rr_issue%0d: got ch=%0d sel=%0d want ch=%0d sel=%0d",
                           k, eng_if.ENG_CH, eng_if.ENG_SEL, exp_ch[k], exp_ch[k]);
      end
      step(); step(); step();
      eng_if.ENG_DONE = 1'b1;
      n_tests++;
      if (eng_if.ENG_CH !== CHW'(exp_ch[k])) begin
        n_fail++; $display("FAIL rr_ch_stable%0d: got %0d want %0d", k, eng_if.ENG_CH, exp_ch[k]);
      end
      step();
      eng_if.ENG_DONE = 1'b0;
      n_tests++;
      if (ack !== 4'(1 << exp_ch[k])) begin
        n_fail++; $display("FAIL rr_ack%0d: got %b want %b", k, ack, 4'(1 << exp_ch[k]));
      end
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got busy=%b want 0", busy); end
    n0 = start_cnt;
    repeat (12) step();
    n_tests++;
    if (start_cnt !== n0) begin n_fail++; $display("FAIL rr_extra_start: got %0d extra want 0", start_cnt - n0); end
  endtask

  task automatic test_timeout();
    int bad, a0, n0;
    req = 4'b0100;
    wait_tick("tmo_tick");
    step(); req = '0;
    step();
    a0 = ack_cnt;
    n_tests++;
    if (eng_if.ENG_START !== 1'b1 || eng_if.ENG_CH !== 2'd2) begin
      n_fail++; $display("FAIL tmo_issue: got start=%b ch=%0d want 1 2", eng_if.ENG_START, eng_if.ENG_CH);
    end
    bad = 0;
    for (int i = 1; i <= TMO; i++) begin step(); if (err !== 1'b0) bad++; end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL tmo_early_err: got %0d early cycles want 0", bad); end
    step();
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b at START+%0d want 1", err, TMO + 1); end
    n_tests++;
    if (ack_cnt !== a0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL tmo_no_ack: got acks=%0d busy=%b want 0 0", ack_cnt - a0, busy);
    end
    n0 = start_cnt;
    repeat (20) step();
    n_tests++;
    if (start_cnt !== n0) begin n_fail++; $display("FAIL tmo_pending_cleared: got %0d restarts want 0", start_cnt - n0); end
    err_clr = 1'b1;
    step(); err_clr = 1'b0;
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clr: got %b want 0", err); end
  endtask

  task automatic test_overrun();
    int n0;
    req = 4'b0010;
    wait_tick("ovr_tick1");
    step();
    step();
    n0 = start_cnt;
    n_tests++;
    if (eng_if.ENG_START !== 1'b1 || eng_if.ENG_CH !== 2'd1) begin
      n_fail++; $display("FAIL ovr_issue: got start=%b ch=%0d want 1 1", eng_if.ENG_START, eng_if.ENG_CH);
    end
    wait_tick("ovr_tick2");
    step();
    n_tests++;
    if (ovr !== 4'b0010) begin n_fail++; $display("FAIL ovr_flag: got %b want 0010", ovr); end
    eng_if.ENG_DONE = 1'b1; req = '0;
    step();
    eng_if.ENG_DONE = 1'b0;
    n_tests++;
    if (ack !== 4'b0010 || err !== 1'b0) begin
      n_fail++; $display("FAIL ovr_done: got ack=%b err=%b want 0010 0", ack, err);
    end
    repeat (40) step();
    n_tests++;
    if (start_cnt !== n0 || ovr !== 4'b0010) begin
      n_fail++; $display("FAIL ovr_served_once: got starts=%0d ovr=%b want 0 0010", start_cnt - n0, ovr);
    end
    err_clr = 1'b1;
    step(); err_clr = 1'b0;
    n_tests++;
    if (ovr !== '0) begin n_fail++; $display("FAIL ovr_clr: got %b want 0000", ovr); end
  endtask

  task automatic test_cfg_during_wait();
    req = 4'b0100;
    wait_tick("cfg_tick1");
    step(); req = '0;
    step();
    n_tests++;
    if (eng_if.ENG_START !== 1'b1 || eng_if.ENG_SEL !== 2'd2) begin
      n_fail++; $display("FAIL cfg_issue1: got start=%b sel=%0d want 1 2", eng_if.ENG_START, eng_if.ENG_SEL);
    end
    step();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_sel = 2'd3;
    step();
    cfg_we = 1'b0;
    n_tests++;
    if (eng_if.ENG_SEL !== 2'd2) begin n_fail++; $display("FAIL cfg_sel_latched: got %0d want 2", eng_if.ENG_SEL); end
    step();
    eng_if.ENG_DONE = 1'b1;
    step();
    eng_if.ENG_DONE = 1'b0;
    n_tests++;
    if (ack !== 4'b0100) begin n_fail++; $display("FAIL cfg_ack1: got %b want 0100", ack); end
    req = 4'b0100;
    wait_tick("cfg_tick2");
    step(); req = '0;
    step();
    n_tests++;
    if (eng_if.ENG_START !== 1'b1 || eng_if.ENG_SEL !== 2'd3) begin
      n_fail++; $display("FAIL cfg_issue2: got start=%b sel=%0d want 1 3", eng_if.ENG_START, eng_if.ENG_SEL);
    end
    step();
  endtask

  task automatic test_async_reset();
    int ticks;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ar_precond: got busy=%b want 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ack, tick, busy, ovr, err, eng_if.ENG_START, eng_if.ENG_CH, eng_if.ENG_SEL} !== '0) begin
      n_fail++; $display("FAIL ar_outputs: got busy=%b ch=%0d sel=%0d ack=%b want all 0",
                         busy, eng_if.ENG_CH, eng_if.ENG_SEL, ack);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0100;
    ticks = 0;
    for (int i = 1; i <= 15; i++) begin step(); if (tick === 1'b1) ticks++; end
    step();
    n_tests++;
    if (ticks !== 0 || tick !== 1'b1) begin
      n_fail++; $display("FAIL ar_tick: got %0d early ticks, tick=%b at 16 want 0 and 1", ticks, tick);
    end
    step(); req = '0;
    step();
    n_tests++;
    if (eng_if.ENG_START !== 1'b1 || eng_if.ENG_CH !== 2'd2 || eng_if.ENG_SEL !== 2'd0) begin
      n_fail++; $display("FAIL ar_table_reset: got start=%b ch=%0d sel=%0d want 1 2 0",
                         eng_if.ENG_START, eng_if.ENG_CH, eng_if.ENG_SEL);
    end
    step(); step(); step();
    eng_if.ENG_DONE = 1'b1;
    step();
    eng_if.ENG_DONE = 1'b0;
    n_tests++;
    if (ack !== 4'b0100) begin n_fail++; $display("FAIL ar_ack: got %b want 0100", ack); end
  endtask

  task automatic test_enable_hold();
    int ticks;
    wait_tick("en_tick");
    step(); en = 1'b0;
    repeat (7) step();
    step(); en = 1'b1;
    ticks = 0;
    for (int i = 10; i <= 23; i++) begin step(); if (tick === 1'b1) ticks++; end
    n_tests++;
    if (ticks !== 0) begin n_fail++; $display("FAIL en_hold_early: got %0d ticks want 0", ticks); end
    step();
    n_tests++;
    if (tick !== 1'b1) begin n_fail++; $display("FAIL en_hold_tick: got %b at T+24 want 1", tick); end
  endtask

  initial begin
    eng_if.ENG_DONE = 1'b0;
    test_reset();
    load_table();
    test_round_robin();
    test_timeout();
    test_overrun();
    test_cfg_during_wait();
    test_async_reset();
    test_enable_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
